// File: rtl/fpu_job_scheduler.sv
// fpu_job_scheduler: FIFO-buffered round-robin dispatch of FPU jobs onto Job Managers with one shared completion port.
// Optional FPU_SCHED_PERF_EN adds saturating perf_jobs/perf_busy counters.
module fpu_job_scheduler #(
  parameter int NUM_JM     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 23,
  parameter int TAG_W      = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [3:0]                 job_op,
  input  logic [TAG_W-1:0]           job_tag,
  input  logic [8*ADDR_W-1:0]        job_desc,
  output logic [NUM_JM-1:0]          jm_avail,
  output logic [4*NUM_JM-1:0]        jm_op,
  output logic [8*ADDR_W*NUM_JM-1:0] jm_desc,
  input  logic [NUM_JM-1:0]          jm_done,
  output logic                       cmp_valid,
  output logic [TAG_W-1:0]           cmp_tag,
  output logic                       idle
`ifdef FPU_SCHED_PERF_EN
  ,
  output logic [31:0]                perf_jobs,
  output logic [31:0]                perf_busy
`endif
);
  localparam int DW = 8*ADDR_W;
  localparam int EW = 4 + TAG_W + DW;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int JW = $clog2(NUM_JM);
  typedef enum logic [1:0] {IDLE, RUN, RETIRE} state_e;
  logic [EW-1:0]    mem_q [FIFO_DEPTH];
  logic [PW:0]      wr_q, wr_d, rd_q, rd_d;
  state_e           st_q [NUM_JM];
  state_e           st_d [NUM_JM];
  logic [3:0]       op_q [NUM_JM];
  logic [3:0]       op_d [NUM_JM];
  logic [TAG_W-1:0] tag_q [NUM_JM];
  logic [TAG_W-1:0] tag_d [NUM_JM];
  logic [DW-1:0]    desc_q [NUM_JM];
  logic [DW-1:0]    desc_d [NUM_JM];
  logic [JW-1:0]    rr_q, rr_d, ret_idx, gnt_idx;
  logic             cmp_valid_q, cmp_valid_d;
  logic [TAG_W-1:0] cmp_tag_q, cmp_tag_d;
  logic             empty, full, push, head_noop, ret_any, found, disp, noop, all_idle;
  logic [EW-1:0]    head;
  always_comb begin
    empty     = wr_q == rd_q;
    full      = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
    head      = mem_q[rd_q[PW-1:0]];
    head_noop = head[EW-1 -: 4] == 4'd0;
    ret_any   = 1'b0;
    ret_idx   = '0;
    for (int i = NUM_JM-1; i >= 0; i--)
      if (st_q[i] == RUN && jm_done[i]) begin
        ret_any = 1'b1;
        ret_idx = JW'(i);
      end
    // scan downward so the candidate closest to the RR pointer is the last one written
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_JM-1; k >= 0; k--)
      if (st_q[(int'(rr_q) + k) % NUM_JM] == IDLE) begin
        found   = 1'b1;
        gnt_idx = JW'((int'(rr_q) + k) % NUM_JM);
      end
    disp        = !empty && !head_noop && found;
    noop        = !empty && head_noop && !ret_any;
    push        = job_valid && !full;
    wr_d        = wr_q + (PW+1)'(push);
    rd_d        = rd_q + (PW+1)'(disp || noop);
    rr_d        = disp ? JW'((int'(gnt_idx) + 1) % NUM_JM) : rr_q;
    cmp_valid_d = ret_any || noop;
    cmp_tag_d   = ret_any ? tag_q[ret_idx] : noop ? head[DW +: TAG_W] : cmp_tag_q;
    for (int i = 0; i < NUM_JM; i++) begin
      st_d[i]   = st_q[i];
      op_d[i]   = op_q[i];
      tag_d[i]  = tag_q[i];
      desc_d[i] = desc_q[i];
      if (st_q[i] == IDLE && disp && gnt_idx == JW'(i)) begin
        st_d[i]   = RUN;
        op_d[i]   = head[EW-1 -: 4];
        tag_d[i]  = head[DW +: TAG_W];
        desc_d[i] = head[DW-1:0];
      end else if (st_q[i] == RUN && ret_any && ret_idx == JW'(i))
        st_d[i] = RETIRE;
      else if (st_q[i] == RETIRE && !jm_done[i])
        st_d[i] = IDLE;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_q[PW-1:0]] <= {job_op, job_tag, job_desc};
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      wr_q        <= '0;
      rd_q        <= '0;
      rr_q        <= '0;
      cmp_valid_q <= 1'b0;
      cmp_tag_q   <= '0;
      for (int i = 0; i < NUM_JM; i++) begin
        st_q[i]   <= IDLE;
        op_q[i]   <= '0;
        tag_q[i]  <= '0;
        desc_q[i] <= '0;
      end
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      rr_q        <= rr_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_tag_q   <= cmp_tag_d;
      for (int i = 0; i < NUM_JM; i++) begin
        st_q[i]   <= st_d[i];
        op_q[i]   <= op_d[i];
        tag_q[i]  <= tag_d[i];
        desc_q[i] <= desc_d[i];
      end
    end
  always_comb begin
    all_idle = 1'b1;
    jm_avail = '0;
    jm_op    = '0;
    jm_desc  = '0;
    for (int i = 0; i < NUM_JM; i++) begin
      all_idle            = all_idle && st_q[i] == IDLE;
      jm_avail[i]         = st_q[i] == RUN;
      jm_op[4*i +: 4]     = op_q[i];
      jm_desc[DW*i +: DW] = desc_q[i];
    end
    job_ready = !full;
    idle      = empty && all_idle;
    cmp_valid = cmp_valid_q;
    cmp_tag   = cmp_tag_q;
  end
`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_jobs_q, perf_jobs_d, perf_busy_q, perf_busy_d;
  always_comb begin
    perf_jobs_d = perf_jobs_q + 32'(cmp_valid_q && perf_jobs_q != '1);
    perf_busy_d = perf_busy_q + 32'(!idle && perf_busy_q != '1);
  end
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      perf_jobs_q <= '0;
      perf_busy_q <= '0;
    end else begin
      perf_jobs_q <= perf_jobs_d;
      perf_busy_q <= perf_busy_d;
    end
  assign perf_jobs = perf_jobs_q;
  assign perf_busy = perf_busy_q;
`endif
endmodule

// File: tb/tb_fpu_job_scheduler.sv
// tb_fpu_job_scheduler: directed test-plan scenarios plus random traffic, checked every cycle against a queue-level model.
module tb_fpu_job_scheduler;
  localparam int N = 4, D = 4, AW = 23, TW = 4, DW = 8*AW;
  logic            clk = 1'b0, rst_l = 1'b1, job_valid = 1'b0;
  logic            job_ready, cmp_valid, idle;
  logic [3:0]      job_op = '0;
  logic [TW-1:0]   job_tag = '0, cmp_tag;
  logic [DW-1:0]   job_desc = '0;
  logic [N-1:0]    jm_avail, jm_done = '0;
  logic [4*N-1:0]  jm_op;
  logic [DW*N-1:0] jm_desc;
  int checks = 0, failures = 0;
`ifdef FPU_SCHED_PERF_EN
  logic [31:0] perf_jobs, perf_busy;
`endif
  fpu_job_scheduler #(.NUM_JM(N), .FIFO_DEPTH(D), .ADDR_W(AW), .TAG_W(TW)) dut (
    .clk(clk), .rst_l(rst_l), .job_valid(job_valid), .job_ready(job_ready),
    .job_op(job_op), .job_tag(job_tag), .job_desc(job_desc),
    .jm_avail(jm_avail), .jm_op(jm_op), .jm_desc(jm_desc), .jm_done(jm_done),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .idle(idle)
`ifdef FPU_SCHED_PERF_EN
    , .perf_jobs(perf_jobs), .perf_busy(perf_busy)
`endif
  );
  always #5 clk = ~clk;
  typedef struct packed {logic [3:0] op; logic [TW-1:0] tag; logic [DW-1:0] desc;} job_t;
  job_t q[$];
  job_t jm[N];
  int js[N];
  int rr;
  logic ev;
  logic [TW-1:0] et;
  task automatic chk(string n, logic [DW-1:0] a, logic [DW-1:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    for (int i = 0; i < N; i++) begin js[i] = 0; jm[i] = '0; end
    rr = 0; ev = 1'b0; et = '0;
  endtask
  task automatic model_edge();
    int win, fr;
    bit noop, disp, was_full;
    was_full = q.size() == D;
    win = -1;
    for (int i = 0; i < N; i++) if (win < 0 && js[i] == 1 && jm_done[i]) win = i;
    fr = -1;
    for (int k = 0; k < N; k++) if (fr < 0 && js[(rr + k) % N] == 0) fr = (rr + k) % N;
    noop = q.size() > 0 && q[0].op == 0 && win < 0;
    disp = q.size() > 0 && q[0].op != 0 && fr >= 0;
    ev = win >= 0 || noop;
    if (win >= 0) et = jm[win].tag; else if (noop) et = q[0].tag;
    for (int i = 0; i < N; i++) if (js[i] == 2 && !jm_done[i]) js[i] = 0;
    if (win >= 0) js[win] = 2;
    if (disp) begin js[fr] = 1; jm[fr] = q[0]; rr = (fr + 1) % N; end
    if (noop || disp) void'(q.pop_front());
    if (job_valid && !was_full) q.push_back({job_op, job_tag, job_desc});
  endtask
  task automatic compare();
    bit all_free;
    all_free = 1'b1;
    for (int i = 0; i < N; i++) all_free = all_free && js[i] == 0;
    chk("job_ready", job_ready, q.size() < D);
    chk("idle", idle, all_free && q.size() == 0);
    chk("cmp_valid", cmp_valid, ev);
    if (ev) chk("cmp_tag", cmp_tag, et);
    for (int i = 0; i < N; i++) begin
      chk("jm_avail", jm_avail[i], js[i] == 1);
      if (js[i] == 1) begin
        chk("jm_op", jm_op[4*i +: 4], jm[i].op);
        chk("jm_desc", jm_desc[DW*i +: DW], jm[i].desc);
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_l) model_edge(); else model_reset();
    #1 compare();
  endtask
  function automatic logic [DW-1:0] rdesc();
    return DW'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
  endfunction
  task automatic drive(logic v, logic [3:0] op, logic [TW-1:0] tag);
    job_valid = v; job_op = op; job_tag = tag; job_desc = rdesc();
  endtask
  task automatic do_reset();
    rst_l = 1'b0; jm_done = '0; job_valid = 1'b0;
    #1 model_reset();
    compare();
    step();
    step();
    rst_l = 1'b1;
  endtask
  initial begin
    #1 rst_l = 1'b0;
    #1 model_reset();
    chk("rst_avail", jm_avail, 0);
    chk("rst_op", jm_op, 0);
    chk("rst_desc", jm_desc, 0);
    chk("rst_cmp_valid", cmp_valid, 0);
    chk("rst_cmp_tag", cmp_tag, 0);
    chk("rst_ready", job_ready, 1);
    chk("rst_idle", idle, 1);
    step();
    rst_l = 1'b1;
    // single job through JM0
    drive(1, 4'd1, 4'd3);
    step();
    job_valid = 1'b0;
    chk("single_not_yet", jm_avail, 0);
    step();
    chk("single_avail", jm_avail, 4'b0001);
    jm_done[0] = 1'b1;
    step();
    chk("single_cmp_valid", cmp_valid, 1);
    chk("single_cmp_tag", cmp_tag, 3);
    chk("single_avail_low", jm_avail, 0);
    step();
    chk("single_pulse_end", cmp_valid, 0);
    jm_done[0] = 1'b0;
    step();
    chk("single_idle", idle, 1);
    // round-robin then simultaneous done
    do_reset();
    for (int t = 0; t < 6; t++) begin drive(1, 4'(t + 1), 4'(t)); step(); end
    job_valid = 1'b0;
    chk("rr_avail", jm_avail, 4'hF);
    chk("rr_ready", job_ready, 1);
    chk("rr_jm2_op", jm_op[11:8], 3);
    jm_done = 4'b1010;
    step();
    chk("sim_first_tag", cmp_tag, 1);
    chk("sim_first_avail", jm_avail, 4'b1101);
    step();
    chk("sim_second_valid", cmp_valid, 1);
    chk("sim_second_tag", cmp_tag, 3);
    jm_done = '0;
    step();
    step();
    step();
    chk("rr_refill_avail", jm_avail, 4'hF);
    chk("rr_refill_jm1", jm_op[7:4], 5);
    chk("rr_refill_jm3", jm_op[15:12], 6);
    // full FIFO
    do_reset();
    for (int t = 0; t < 8; t++) begin drive(1, 4'(t + 1), 4'(t)); step(); end
    chk("full_ready_low", job_ready, 0);
    drive(1, 4'd9, 4'd8);
    step();
    chk("full_rejected", job_ready, 0);
    job_valid = 1'b0;
    jm_done[0] = 1'b1;
    step();
    chk("full_ret_tag", cmp_tag, 0);
    jm_done[0] = 1'b0;
    step();
    step();
    chk("full_jm0_op", jm_op[3:0], 5);
    chk("full_jm0_avail", jm_avail[0], 1);
    chk("full_ready_back", job_ready, 1);
    // NOOP versus retirement
    do_reset();
    for (int t = 0; t < 3; t++) begin drive(1, 4'(t + 1), 4'(t)); step(); end
    drive(1, 4'd0, 4'd7);
    step();
    job_valid = 1'b0;
    jm_done[2] = 1'b1;
    step();
    chk("noop_first_valid", cmp_valid, 1);
    chk("noop_first_tag", cmp_tag, 2);
    step();
    chk("noop_second_valid", cmp_valid, 1);
    chk("noop_second_tag", cmp_tag, 7);
    jm_done[2] = 1'b0;
    step();
    chk("noop_done", cmp_valid, 0);
    // reset mid-run: two running, two retiring, two queued
    do_reset();
    for (int t = 0; t < 6; t++) begin drive(1, 4'(t + 1), 4'(t)); step(); end
    job_valid = 1'b0;
    jm_done = 4'b1100;
    step();
    step();
    chk("mid_pre_avail", jm_avail, 4'b0011);
    #2 rst_l = 1'b0;
    #1 model_reset();
    chk("mid_avail", jm_avail, 0);
    chk("mid_cmp_valid", cmp_valid, 0);
    chk("mid_idle", idle, 1);
    chk("mid_op", jm_op, 0);
    compare();
    jm_done = '0;
    step();
    rst_l = 1'b1;
    for (int t = 0; t < 5; t++) begin step(); chk("mid_no_cmp", cmp_valid, 0); end
    chk("mid_idle_after", idle, 1);
    // random traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      drive(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)), 4'($urandom()));
      for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) jm_done[i] = ~jm_done[i];
      if (!rst_l) rst_l = 1'b1;
      else if ($urandom_range(0, 399) == 0) begin
        #2 rst_l = 1'b0;
        #1 model_reset();
        compare();
      end
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fpu_job_scheduler.md
# fpu_job_scheduler

Dispatches queued FPU jobs (opcode plus four memory-region descriptors a/b/c/d) onto an array of FPU Job Managers inside the FPU Bank. It buffers incoming jobs in a small FIFO and picks a free Job Manager round-robin. It drives each Job Manager's avail/done handshake and reports each retired job's tag on a completion port. Upstream is the model-level sequencer; downstream are NUM_JM Job Managers, each owning its own memory ports.

## Interface
- NUM_JM, 4, number of Job Managers served (2..8)
- FIFO_DEPTH, 4, job FIFO entries (power of two, ≥2)
- ADDR_W, 23, region address width
- TAG_W, 4, job tag width
- clk  in  1  clock
- rst_l  in  1  reset, asynchronous, active-low
- job_valid  in  1  upstream job present
- job_ready  out  1  FIFO not full
- job_op  in  4  op_id encoding; NOOP = 0
- job_tag  in  TAG_W  job identifier echoed on completion
- job_desc  in  8*ADDR_W  {d_end,d_begin,c_end,c_begin,b_end,b_begin,a_end,a_begin}, a_begin at LSBs
- jm_avail  out  NUM_JM  per-JM job-valid level
- jm_op  out  4*NUM_JM  per-JM opcode, stable while avail high
- jm_desc  out  8*ADDR_W*NUM_JM  per-JM descriptor, stable while avail high
- jm_done  in  NUM_JM  per-JM completion level
- cmp_valid  out  1  one-cycle completion pulse
- cmp_tag  out  TAG_W  tag of the retired job
- idle  out  1  FIFO empty and all JMs IDLE

## Operation
- Accept: job_valid && job_ready at a clock edge pushes {op,tag,desc}. job_ready = !full. No push-on-pop bypass when full.
- Per-JM FSM:
  - IDLE: avail=0.
  - RUN: avail=1; op/desc/tag latched at dispatch.
  - RETIRE: avail=0; waits for done to fall.
- Transitions:
  - IDLE→RUN on dispatch.
  - RUN→RETIRE when jm_done=1 and this JM wins the completion port.
  - RETIRE→IDLE when jm_done=0.
- Dispatch: at most one per cycle. Head is non-NOOP and at least one JM is IDLE → pop, grant by round-robin. The pointer starts at JM0 and advances to the granted index + 1 after each grant.
- Completion port: one retirement per cycle. Among RUN JMs with done=1, the lowest index wins. Losers stay in RUN with avail high until they win.
- NOOP head: popped and retired without a JM (cmp_valid, cmp_tag = its tag), only when no JM retirement claims the port that cycle. Otherwise the head stalls.
- Dispatch and a retirement or NOOP retire may coincide.
- jm_done rising while in IDLE or RETIRE is ignored.
- Reset mid-operation: FIFO flushed, all FSMs to IDLE, avail dropped. In-flight jobs are lost and produce no completion.

## Timing
- Reset values:
  - jm_avail=0, jm_op=0, jm_desc=0
  - cmp_valid=0, cmp_tag=0
  - job_ready=1, idle=1
  - RR pointer=0
- Job accepted at edge t into an empty FIFO with a free JM: jm_avail rises after edge t+1 (1-cycle dispatch latency).
- jm_done sampled high at edge t (winner): jm_avail low and cmp_valid high during cycle t..t+1; cmp_valid lasts exactly one cycle.
- RETIRE→IDLE at the edge that samples done=0; the JM is dispatchable at the following edge.
- NOOP: accepted at t, cmp_valid during cycle t+1..t+2 if the port is free.
- job_ready drops the cycle after the push that fills the FIFO. It rises the cycle after the pop that frees a slot.
- All outputs registered; no combinational path from jm_done or job_valid to any output.

## Configuration
- FPU_SCHED_PERF_EN defined: adds outputs perf_jobs (32-bit) and perf_busy (32-bit).
  - perf_jobs increments on each cmp_valid.
  - perf_busy increments each cycle idle=0.
  - Both saturate at all-ones and reset to 0.
- Undefined: ports absent, no counter logic.

## Test plan
- Single job: push op=LINEAR_FW, tag=3 with all JMs free. Required: jm_avail[0] rises 1 cycle after accept; hold jm_done[0]=1 for 2 cycles. Required: one cmp_valid pulse with cmp_tag=3, then jm_avail[0]=0, idle=1 after done falls.
- Round-robin: push 6 jobs (tags 0..5) back-to-back with done held low. Required: grants to JM0,1,2,3; tags 4,5 remain in the FIFO; job_ready stays 1.
- Simultaneous done: assert jm_done[1] and jm_done[3] in the same cycle. Required: tag of JM1 completes first, tag of JM3 on the next cycle, jm_avail[3] high until its retirement.
- Full FIFO: all JMs busy, push 4 jobs. Required: job_ready=0 after the 4th; a 5th job_valid is not accepted. Retire JM0. Required: oldest queued job dispatches to JM0 and job_ready returns to 1.
- NOOP vs retirement: NOOP tag=7 at head while jm_done[2] rises. Required: JM2's tag completes first, tag 7 on the next cycle.
- Reset mid-run: assert rst_l=0 with 2 JMs in RUN and 2 queued jobs. Required: all avail=0 immediately, no cmp_valid after release, idle=1.
